cs_adder_seq: RTL
=================

Name: cs_adder_seq

Overview:
- Sequencer for the packet lane adder, which computes c = a + {b, ..., b, b_0} per lane.
- On each job it clears an internal packet accumulator, then feeds it back through the adder once per accepted input beat, for num_terms beats.
- When the job completes it presents the accumulated packet on a valid/ready output.
- Sits between the measurement-coefficient stream and the register bank in the compressed-sensing prediction path.

Parameters:
- DATA_WIDTH, 8: lane width in bits.
- REG_BANK_DEPTH, 16: number of lanes per packet.
- PACKET_LEN, DATA_WIDTH*REG_BANK_DEPTH: packet width; derived, not overridden.
- CNT_WIDTH, 8: width of the term counter and of num_terms.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  job start pulse; sampled only in IDLE.
- num_terms  in  CNT_WIDTH  beats to accumulate; latched on accepted start.
- busy  out  1  high in ACCUM and HOLD.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat ready.
- in_b0  in  DATA_WIDTH  addend for lane 0.
- in_b  in  DATA_WIDTH  addend for lanes 1..REG_BANK_DEPTH-1.
- add_a  out  PACKET_LEN  to adder a; equals the accumulator.
- add_b0  out  DATA_WIDTH  to adder b_0; equals in_b0.
- add_b  out  DATA_WIDTH  to adder b; equals in_b.
- add_c  in  PACKET_LEN  from adder c.
- out_valid  out  1  result valid.
- out_ready  in  1  result ready.
- out_data  out  PACKET_LEN  result packet; equals the accumulator.
- done  out  1  one-cycle pulse on the cycle the result handshake completes.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE; acc=0; count=0; busy, in_ready, out_valid, done=0; out_data=0.
- Adder connection: add_a, add_b0, add_b are combinational passthroughs. The adder is combinational; add_c is captured in the same cycle as the beat.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with num_terms=N latches N, clears acc and count.
  - N>0 -> ACCUM. N=0 -> HOLD (acc=0).
- ACCUM:
  - in_ready=1.
  - Each cycle with in_valid&in_ready: acc<=add_c; count<=count+1.
  - On the beat where count==N-1 the state goes to HOLD; out_valid=1 the next cycle.
  - Cycles without in_valid leave acc and count unchanged.
  - First beat can be accepted the cycle after start.
- HOLD:
  - in_ready=0; out_valid=1; out_data=acc, stable until the handshake.
  - out_valid&out_ready -> IDLE next cycle, with done=1 in the handshake cycle.
  - start in HOLD is ignored.
  - A new start is accepted no earlier than the cycle after the handshake.
- Ignored starts: start in ACCUM or HOLD is ignored; no relatch and no acc clear.
- Arithmetic: per-lane modulo 2^DATA_WIDTH wrap, inherited from the adder. No saturation, no overflow flag.
- Counter range: N up to 2^CNT_WIDTH-1. count never wraps within a job.
- Reset mid-operation: an asserted rst overrides all other inputs. The in-flight job is dropped with no output.
- Simultaneous rst and start: rst wins and start is lost.
- Throughput: N beats + 1 HOLD cycle minimum per job, plus 1 IDLE cycle between jobs.

Test Plan (DATA_WIDTH=8, REG_BANK_DEPTH=4, add_c driven by a lane-adder model in the bench):
- Basic accumulate:
  - Stimulus: start, N=3; beats (b0,b)=(1,2),(3,4),(5,6), back-to-back, out_ready=1.
  - Required: out_valid one cycle after the third beat; out_data lanes = {12,12,12,9} (lane0=9); done pulses once.
- Wrap-around:
  - Stimulus: N=2; beats (200,250),(100,10).
  - Required: lane0=44, lanes1..3=4.
- Zero terms:
  - Stimulus: start, N=0.
  - Required: in_ready never high; out_valid the cycle after start; out_data=0.
- Backpressure and stalls:
  - Stimulus: N=2, in_valid gaps of 3 cycles, then out_ready held low 5 cycles; start pulsed during ACCUM and HOLD.
  - Required: out_data stable while waiting; busy=1 throughout; the ignored starts leave the result unchanged; done only on the handshake.
- Reset mid-job:
  - Stimulus: N=4, one beat (9,9) accepted, then rst for one cycle.
  - Required: next cycle busy=0, out_valid=0, in_ready=0.
  - Follow-on: new job N=1 with beat (7,8) gives lane0=7, lanes1..3=8, proving acc was cleared.
- Back-to-back jobs:
  - Stimulus: job N=1 (1,1), then start the cycle after the handshake, N=1 (2,3).
  - Required: second result lane0=2, others=3; no carry-over from the first job.

Source files
------------

// File: rtl/cs_adder_seq.sv
// Sequencer for the packet lane adder: clears an accumulator per job, folds
// num_terms input beats through the external adder, then offers the packet.
module cs_adder_seq #(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_BANK_DEPTH = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [CNT_WIDTH-1:0]                 num_terms,
    output logic                                 busy,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH-1:0]                in_b0,
    input  logic [DATA_WIDTH-1:0]                in_b,
    output logic [DATA_WIDTH*REG_BANK_DEPTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0]                add_b0,
    output logic [DATA_WIDTH-1:0]                add_b,
    input  logic [DATA_WIDTH*REG_BANK_DEPTH-1:0] add_c,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_WIDTH*REG_BANK_DEPTH-1:0] out_data,
    output logic                                 done
);

    localparam int PACKET_LEN = DATA_WIDTH * REG_BANK_DEPTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PACKET_LEN-1:0] acc;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  n_lat;
    logic                  accept_start;
    logic                  beat;
    logic                  last_beat;

    assign add_a    = acc;
    assign add_b0   = in_b0;
    assign add_b    = in_b;
    assign out_data = acc;

    // n_lat is never zero while in ACCUM, so n_lat-1 cannot underflow here.
    assign last_beat = (count == n_lat - CNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        done         = 1'b0;
        accept_start = 1'b0;
        beat         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_next   = (num_terms == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                beat     = in_valid;
                if (in_valid && last_beat) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            n_lat <= '0;
        end else if (accept_start) begin
            acc   <= '0;
            count <= '0;
            n_lat <= num_terms;
        end else if (beat) begin
            acc   <= add_c;
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule
